wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Writeback end of the MEM/WB interface: consumes the MEM/WB pipeline register outputs and retires each instruction.
//  Selects the writeback data, writes the 8x16 general register file and the SZCV flag register, and counts retired instructions.
//  Serves the ID stage through two combinational read ports.
//  Sits after the MEM/WB register and feeds the ID/EX stage; it is the only owner of architectural register and flag state.
// PARAMETERS
//  DATA_W   16  datapath / register width
//  ADDR_W   3   register address width
//  NREG     8   number of general registers (2**ADDR_W)
//  CNT_W    32  retire counter width
// PORTS
//  clk                    in   1       clock, rising edge
//  reset                  in   1       asynchronous, active-high; clears all state
//  ALUres_wb              in   DATA_W  ALU result from MEM/WB
//  rd1_wb                 in   DATA_W  register operand 1 passed down the pipe
//  extended_d_wb          in   DATA_W  sign/zero-extended immediate
//  main_mem_dat_wb        in   DATA_W  load data from main memory
//  S_wb, C_wb, Z_wb, V_wb in   1 each  flags produced by the instruction
//  regwrite               in   1       write register file this cycle
//  regwrite_dat_controll  in   2       writeback source select (wb_sel_t)
//  regwrite_adr           in   ADDR_W  destination register
//  flagwrite_wb           in   1       update SZCV this cycle
//  valid_wb               in   1       slot holds a real instruction (0 = bubble/flushed)
//  ra1, ra2               in   ADDR_W  ID-stage read addresses
//  rd1, rd2               out  DATA_W  ID-stage read data
//  flags                  out  4       {S,Z,C,V} architectural flag register
//  wb_dat                 out  DATA_W  selected writeback data (for EX forwarding)
//  retired                out  CNT_W   retired-instruction counter
// BEHAVIOUR
//  - Reset (async, any time): all NREG registers = 0, flags = 4'b0000, retired = 0; a write in the reset cycle is dropped.
//  - wb_dat is combinational: WB_ALU(00)=ALUres_wb, WB_MEM(01)=main_mem_dat_wb, WB_RD1(10)=rd1_wb, WB_EXT(11)=extended_d_wb.
//  - Register write: at rising clk, if regwrite, reg[regwrite_adr] <= wb_dat. The result is visible on rd1/rd2 one cycle later (see CONFIGURATION).
//    r0 is an ordinary register; there is no hardwired zero.
//  - Flag write: at rising clk, if flagwrite_wb, flags <= {S_wb,Z_wb,C_wb,V_wb}. Otherwise flags hold.
//    Flags are independent of regwrite.
//  - Retire counter: at rising clk, if valid_wb, retired <= retired + 1, wrapping modulo 2**CNT_W (all-ones -> 0).
//  - regwrite/flagwrite are honoured regardless of valid_wb. A flushed MEM/WB register presents all-zero controls, so a bubble writes nothing.
//  - Reads: rd1/rd2 are combinational on ra1/ra2. ra1==ra2 returns the same value on both ports.
//  - Latency: writeback is zero-cycle combinational data; architectural state updates at the same edge that ends the WB stage.
// CONFIGURATION
//  - Macro WB_BYPASS_EN. Defined: write-through bypass. If regwrite && ra==regwrite_adr, that port returns wb_dat in the same cycle.
//    This applies to each port independently.
//  - Not defined: ports always return stored contents. The hazard unit must stall one extra cycle on a RAW with WB.
// STRUCTURE
//  - Package core_pkg (shared):
//    - typedef enum logic [1:0] wb_sel_t {WB_ALU, WB_MEM, WB_RD1, WB_EXT}
//    - localparams DATA_W, ADDR_W, NREG
//    - flag bit index constants FLAG_S=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
//  - Sub-module regfile: NREG x DATA_W array, one write port, two read ports, async reset, bypass logic under WB_BYPASS_EN.
//  - Top level holds the wb_dat mux, flag register and retire counter.
// TESTING
//  1. Assert reset mid-run after writing r3=16'h1234 -> rd1(ra1=3)=0, flags=0, retired=0 immediately, without waiting for a clk edge.
//  2. Drive sel=WB_MEM, main_mem_dat_wb=16'hBEEF, regwrite=1, adr=5 -> next cycle rd2(ra2=5)=16'hBEEF.
//     Repeat for each source; wb_dat matches the selected input every cycle.
//  3. Same-cycle read of reg being written with value 16'h00A5 -> rd1=16'h00A5 with WB_BYPASS_EN, old value without.
//     Both builds read 16'h00A5 the following cycle.
//  4. flagwrite_wb=1, {S,Z,C,V}=1010 with regwrite=0 -> flags=4'b1010, registers unchanged.
//     flagwrite_wb=0 next cycle with different flag inputs -> flags still 1010.
//  5. All-zero (flushed) inputs with valid_wb=0 for 4 cycles -> no register/flag change, retired unchanged.
//  6. Preload retired near wrap (CNT_W=4 build), 3 valid instructions from 4'hE -> 4'hF, 4'h0, 4'h1.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: types and constants shared across the core pipeline.
//   wb_sel_t   writeback source select (ALU / memory / operand 1 / immediate)
//   DATA_W, ADDR_W, NREG   datapath width, register address width, register count
//   FLAG_*     bit positions of S, Z, C, V within the 4-bit flag register
package core_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREG   = 1 << ADDR_W;

    localparam int unsigned FLAG_S = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_RD1 = 2'b10,
        WB_EXT = 2'b11
    } wb_sel_t;

endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: bundles the MEM/WB pipeline outputs, the ID-stage read ports and
// the writeback-stage status outputs.
//   master modport: the pipeline side (drives MEM/WB fields and read addresses)
//   slave modport:  the writeback stage (returns read data, flags, wb_dat, retired)
// CNT_W must match the CNT_W of the wb_regfile instance attached to the slave side.
interface wb_regfile_if #(
    parameter int unsigned CNT_W = 32
) ();
    import core_pkg::*;

    // MEM/WB register outputs
    logic [DATA_W-1:0] ALUres_wb;
    logic [DATA_W-1:0] rd1_wb;
    logic [DATA_W-1:0] extended_d_wb;
    logic [DATA_W-1:0] main_mem_dat_wb;
    logic              S_wb;
    logic              C_wb;
    logic              Z_wb;
    logic              V_wb;
    logic              regwrite;
    wb_sel_t           regwrite_dat_controll;
    logic [ADDR_W-1:0] regwrite_adr;
    logic              flagwrite_wb;
    logic              valid_wb;

    // ID-stage read ports
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    // Writeback-stage status
    logic [3:0]        flags;
    logic [DATA_W-1:0] wb_dat;
    logic [CNT_W-1:0]  retired;

    modport master (
        output ALUres_wb, rd1_wb, extended_d_wb, main_mem_dat_wb,
        output S_wb, C_wb, Z_wb, V_wb,
        output regwrite, regwrite_dat_controll, regwrite_adr, flagwrite_wb, valid_wb,
        output ra1, ra2,
        input  rd1, rd2, flags, wb_dat, retired
    );

    modport slave (
        input  ALUres_wb, rd1_wb, extended_d_wb, main_mem_dat_wb,
        input  S_wb, C_wb, Z_wb, V_wb,
        input  regwrite, regwrite_dat_controll, regwrite_adr, flagwrite_wb, valid_wb,
        input  ra1, ra2,
        output rd1, rd2, flags, wb_dat, retired
    );

endinterface

// File: rtl/regfile.sv
// regfile: NREG x DATA_W general register file, one write port, two combinational
// read ports, asynchronous active-high reset clearing every register.
//   clk, reset        clock (rising edge) and async reset
//   we, wa, wd        write enable / address / data, applied at the rising edge
//   ra1, ra2          read addresses
//   rd1, rd2          read data
// Optional feature: `define WB_BYPASS_EN makes each read port return wd in the same
// cycle when we is set and its address matches wa. Without it, reads return stored
// contents only.
module regfile
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] mem_q [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wa] <= wd;
        end
    end

`ifdef WB_BYPASS_EN
    // Write-through: each port independently forwards the value being written.
    always_comb begin
        rd1 = mem_q[ra1];
        rd2 = mem_q[ra2];
        if (we && (ra1 == wa)) begin
            rd1 = wd;
        end
        if (we && (ra2 == wa)) begin
            rd2 = wd;
        end
    end
`else
    // No forwarding: the hazard unit stalls an extra cycle on a RAW against WB.
    always_comb begin
        rd1 = mem_q[ra1];
        rd2 = mem_q[ra2];
    end
`endif

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage. Selects the writeback data from the MEM/WB fields,
// writes the general register file and the SZCV flag register, counts retired
// instructions and serves the ID stage through two combinational read ports.
//   clk     rising-edge clock
//   reset   asynchronous, active-high; clears registers, flags and retire counter
//   bus     wb_regfile_if.slave: MEM/WB inputs, ra1/ra2 -> rd1/rd2, flags, wb_dat,
//           retired
// Parameter CNT_W sets the retire counter width (wraps modulo 2**CNT_W).
// Optional feature: `define WB_BYPASS_EN enables same-cycle write-through on the
// read ports (implemented in regfile).
module wb_regfile
    import core_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);

    logic [DATA_W-1:0] wb_dat;
    logic [3:0]        flags_q;
    logic [3:0]        flags_d;
    logic [CNT_W-1:0]  retired_q;
    logic [CNT_W-1:0]  retired_d;

    always_comb begin
        wb_dat = bus.ALUres_wb;
        unique case (bus.regwrite_dat_controll)
            WB_ALU:  wb_dat = bus.ALUres_wb;
            WB_MEM:  wb_dat = bus.main_mem_dat_wb;
            WB_RD1:  wb_dat = bus.rd1_wb;
            WB_EXT:  wb_dat = bus.extended_d_wb;
            default: wb_dat = bus.ALUres_wb;
        endcase
    end

    regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (bus.regwrite),
        .wa    (bus.regwrite_adr),
        .wd    (wb_dat),
        .ra1   (bus.ra1),
        .ra2   (bus.ra2),
        .rd1   (bus.rd1),
        .rd2   (bus.rd2)
    );

    // Flags update independently of regwrite; a bubble carries flagwrite_wb = 0.
    always_comb begin
        flags_d = flags_q;
        if (bus.flagwrite_wb) begin
            flags_d[FLAG_S] = bus.S_wb;
            flags_d[FLAG_Z] = bus.Z_wb;
            flags_d[FLAG_C] = bus.C_wb;
            flags_d[FLAG_V] = bus.V_wb;
        end
    end

    always_comb begin
        retired_d = retired_q;
        if (bus.valid_wb) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q   <= '0;
            retired_q <= '0;
        end else begin
            flags_q   <= flags_d;
            retired_q <= retired_d;
        end
    end

    assign bus.wb_dat  = wb_dat;
    assign bus.flags   = flags_q;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: self-checking bench for wb_regfile. Uses a 4-bit retire counter so
// the wrap-around can be reached in a few cycles. Expected register writes go
// through a scoreboard queue; a small architectural model tracks regs/flags/count.
module tb_wb_regfile;
    import core_pkg::*;

    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
    } sb_t;

    logic clk;
    logic reset;

    wb_regfile_if #(.CNT_W(CNT_W)) bus ();

    wb_regfile #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] mem_m [NREG];
    logic [3:0]        flags_m;
    logic [CNT_W-1:0]  ret_m;
    sb_t               sb_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, time %0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] sel_m(input wb_sel_t s);
        logic [DATA_W-1:0] r;
        case (s)
            WB_MEM:  r = bus.main_mem_dat_wb;
            WB_RD1:  r = bus.rd1_wb;
            WB_EXT:  r = bus.extended_d_wb;
            default: r = bus.ALUres_wb;
        endcase
        return r;
    endfunction

    task automatic clear_inputs();
        bus.ALUres_wb             = '0;
        bus.rd1_wb                = '0;
        bus.extended_d_wb         = '0;
        bus.main_mem_dat_wb       = '0;
        bus.S_wb                  = 1'b0;
        bus.C_wb                  = 1'b0;
        bus.Z_wb                  = 1'b0;
        bus.V_wb                  = 1'b0;
        bus.regwrite              = 1'b0;
        bus.regwrite_dat_controll = WB_ALU;
        bus.regwrite_adr          = '0;
        bus.flagwrite_wb          = 1'b0;
        bus.valid_wb              = 1'b0;
        bus.ra1                   = '0;
        bus.ra2                   = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mem_m[i] = '0;
        flags_m = '0;
        ret_m   = '0;
    endtask

    // Advance the model from the currently driven inputs, then cross one rising edge.
    task automatic step();
        if (reset) begin
            model_reset();
        end else begin
            if (bus.regwrite) mem_m[bus.regwrite_adr] = sel_m(bus.regwrite_dat_controll);
            if (bus.flagwrite_wb) flags_m = {bus.S_wb, bus.Z_wb, bus.C_wb, bus.V_wb};
            if (bus.valid_wb) ret_m = ret_m + CNT_W'(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < NREG; i++) begin
            bus.ra1 = ADDR_W'(i);
            #1;
            n_checks++;
            if (bus.rd1 !== mem_m[i]) begin
                n_fail++;
                $display("FAIL %s r%0d: got %h required %h", tag, i, bus.rd1, mem_m[i]);
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        model_reset();
        step();
        step();
        check_all_regs("reset_regs");
        n_checks++;
        if (bus.flags !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b required 0000", bus.flags);
        end
        n_checks++;
        if (bus.retired !== CNT_W'(0)) begin
            n_fail++; $display("FAIL reset_retired: got %h required 0", bus.retired);
        end
        // A write presented while reset is held must be dropped.
        bus.regwrite = 1'b1; bus.regwrite_adr = 3'd2; bus.ALUres_wb = 16'hFFFF;
        bus.valid_wb = 1'b1; bus.flagwrite_wb = 1'b1;
        {bus.S_wb, bus.Z_wb, bus.C_wb, bus.V_wb} = 4'b1111;
        step();
        clear_inputs();
        bus.ra1 = 3'd2;
        #1;
        n_checks++;
        if (bus.rd1 !== 16'h0000 || bus.flags !== 4'b0000 || bus.retired !== CNT_W'(0)) begin
            n_fail++;
            $display("FAIL reset_drop: got rd1=%h flags=%b retired=%h required 0000/0000/0",
                     bus.rd1, bus.flags, bus.retired);
        end
        reset = 1'b0;
        // Write r3 and flags, then assert reset mid-cycle.
        bus.regwrite = 1'b1; bus.regwrite_adr = 3'd3; bus.ALUres_wb = 16'h1234;
        bus.valid_wb = 1'b1; bus.flagwrite_wb = 1'b1;
        {bus.S_wb, bus.Z_wb, bus.C_wb, bus.V_wb} = 4'b1111;
        step();
        clear_inputs();
        bus.ra1 = 3'd3;
        #1;
        n_checks++;
        if (bus.rd1 !== 16'h1234 || bus.flags !== 4'b1111 || bus.retired !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL pre_reset_write: got rd1=%h flags=%b retired=%h required 1234/1111/1",
                     bus.rd1, bus.flags, bus.retired);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (bus.rd1 !== 16'h0000 || bus.flags !== 4'b0000 || bus.retired !== CNT_W'(0)) begin
            n_fail++;
            $display("FAIL async_reset: got rd1=%h flags=%b retired=%h required 0000/0000/0",
                     bus.rd1, bus.flags, bus.retired);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_sources();
        wb_sel_t           sels [4] = '{WB_MEM, WB_ALU, WB_RD1, WB_EXT};
        logic [ADDR_W-1:0] adrs [4] = '{3'd5, 3'd1, 3'd2, 3'd7};
        logic [DATA_W-1:0] vals [4] = '{16'hBEEF, 16'hC0DE, 16'h5A5A, 16'h8001};
        sb_t               e;
        for (int k = 0; k < 4; k++) begin
            clear_inputs();
            // Every source carries a distinct value so a wrong select is visible.
            bus.ALUres_wb       = vals[k] ^ 16'h0101;
            bus.main_mem_dat_wb = vals[k] ^ 16'h0202;
            bus.rd1_wb          = vals[k] ^ 16'h0404;
            bus.extended_d_wb   = vals[k] ^ 16'h0808;
            case (sels[k])
                WB_ALU:  bus.ALUres_wb       = vals[k];
                WB_MEM:  bus.main_mem_dat_wb = vals[k];
                WB_RD1:  bus.rd1_wb          = vals[k];
                default: bus.extended_d_wb   = vals[k];
            endcase
            bus.regwrite_dat_controll = sels[k];
            bus.regwrite              = 1'b1;
            bus.regwrite_adr          = adrs[k];
            bus.valid_wb              = 1'b1;
            sb_q.push_back('{adr: adrs[k], dat: vals[k]});
            #1;
            n_checks++;
            if (bus.wb_dat !== vals[k]) begin
                n_fail++;
                $display("FAIL wb_dat sel=%0d: got %h required %h", k, bus.wb_dat, vals[k]);
            end
            step();
            clear_inputs();
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: got size 0 required 1");
            end else begin
                e = sb_q.pop_front();
                bus.ra2 = e.adr;
                #1;
                if (bus.rd2 !== e.dat) begin
                    n_fail++;
                    $display("FAIL write_src%0d r%0d: got %h required %h",
                             k, e.adr, bus.rd2, e.dat);
                end
            end
        end
        n_checks++;
        if (bus.retired !== ret_m) begin
            n_fail++; $display("FAIL src_retired: got %h required %h", bus.retired, ret_m);
        end
        check_all_regs("src_regs");
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp_same;
        clear_inputs();
        bus.regwrite = 1'b1; bus.regwrite_adr = 3'd6; bus.ALUres_wb = 16'h0F0F;
        step();
        clear_inputs();
        bus.regwrite_dat_controll = WB_EXT;
        bus.extended_d_wb         = 16'h00A5;
        bus.regwrite              = 1'b1;
        bus.regwrite_adr          = 3'd6;
        bus.ra1                   = 3'd6;
        bus.ra2                   = 3'd4;
`ifdef WB_BYPASS_EN
        exp_same = 16'h00A5;
`else
        exp_same = 16'h0F0F;
`endif
        #1;
        n_checks++;
        if (bus.rd1 !== exp_same) begin
            n_fail++; $display("FAIL bypass_rd1: got %h required %h", bus.rd1, exp_same);
        end
        n_checks++;
        if (bus.rd2 !== mem_m[4]) begin
            n_fail++; $display("FAIL bypass_other_port: got %h required %h", bus.rd2, mem_m[4]);
        end
        bus.ra2 = 3'd6;
        #1;
        n_checks++;
        if (bus.rd2 !== exp_same) begin
            n_fail++; $display("FAIL bypass_rd2: got %h required %h", bus.rd2, exp_same);
        end
        step();
        bus.regwrite = 1'b0;
        #1;
        n_checks++;
        if (bus.rd1 !== 16'h00A5 || bus.rd2 !== 16'h00A5) begin
            n_fail++;
            $display("FAIL bypass_next: got rd1=%h rd2=%h required 00a5/00a5", bus.rd1, bus.rd2);
        end
    endtask

    task automatic test_flags();
        clear_inputs();
        bus.flagwrite_wb = 1'b1;
        {bus.S_wb, bus.Z_wb, bus.C_wb, bus.V_wb} = 4'b1010;
        bus.ALUres_wb = 16'hDEAD;
        step();
        clear_inputs();
        n_checks++;
        if (bus.flags !== 4'b1010) begin
            n_fail++; $display("FAIL flag_write: got %b required 1010", bus.flags);
        end
        check_all_regs("flag_regs");
        {bus.S_wb, bus.Z_wb, bus.C_wb, bus.V_wb} = 4'b0101;
        step();
        n_checks++;
        if (bus.flags !== 4'b1010) begin
            n_fail++; $display("FAIL flag_hold: got %b required 1010", bus.flags);
        end
        bus.flagwrite_wb = 1'b1;
        {bus.S_wb, bus.Z_wb, bus.C_wb, bus.V_wb} = 4'b0110;
        step();
        clear_inputs();
        n_checks++;
        if (bus.flags !== 4'b0110) begin
            n_fail++; $display("FAIL flag_write2: got %b required 0110", bus.flags);
        end
    endtask

    task automatic test_bubble();
        logic [3:0]       flags_before;
        logic [CNT_W-1:0] ret_before;
        clear_inputs();
        flags_before = flags_m;
        ret_before   = ret_m;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (bus.retired !== ret_before || bus.flags !== flags_before) begin
                n_fail++;
                $display("FAIL bubble cycle %0d: got retired=%h flags=%b required %h/%b",
                         c, bus.retired, bus.flags, ret_before, flags_before);
            end
        end
        check_all_regs("bubble_regs");
    endtask

    task automatic test_retire_wrap();
        logic [CNT_W-1:0] gap;
        logic [CNT_W-1:0] exp_seq [3] = '{4'hF, 4'h0, 4'h1};
        clear_inputs();
        bus.valid_wb = 1'b1;
        gap = CNT_W'(14) - ret_m;
        for (int c = 0; c < int'(gap); c++) step();
        n_checks++;
        if (bus.retired !== 4'hE) begin
            n_fail++; $display("FAIL retire_preload: got %h required e", bus.retired);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (bus.retired !== exp_seq[c]) begin
                n_fail++;
                $display("FAIL retire_wrap %0d: got %h required %h", c, bus.retired, exp_seq[c]);
            end
        end
        clear_inputs();
        check_all_regs("retire_regs");
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_sources();
        test_bypass();
        test_flags();
        test_bubble();
        test_retire_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
